// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module : tmds_pkg
// Brief  : Shared constants and state encoding for the TMDS serial scheduler.
// Rev    : 1.0
// ============================================================================
package tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] IDLE_SYM = 10'b1101010100;

  // Control symbols indexed by {C1,C0}
  localparam logic [SYM_W-1:0] CTRL_SYM [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  localparam logic [SYM_W-1:0] CLK_PATTERN = 10'b0000011111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tmds_serial_sched_if.sv
`default_nettype none
// ============================================================================
// Module : tmds_serial_sched_if
// Brief  : Symbol-triple valid/ready handshake between encoders and scheduler.
// Rev    : 1.0
// ============================================================================
interface tmds_serial_sched_if;
  import tmds_pkg::*;

  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] sym_b;
  logic [SYM_W-1:0] sym_g;
  logic [SYM_W-1:0] sym_r;

  modport master (output sym_valid, sym_b, sym_g, sym_r, input sym_ready);
  modport slave  (input sym_valid, sym_b, sym_g, sym_r, output sym_ready);

endinterface
`default_nettype wire

// File: rtl/tmds_lane_shift.sv
`default_nettype none
// ============================================================================
// Module : tmds_lane_shift
// Brief  : One-lane symbol shifter, LSB first, with registered serial output.
// Rev    : 1.0
// ============================================================================
module tmds_lane_shift
  import tmds_pkg::*;
#(
  parameter int W = SYM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] sym_i,
  output logic         ser_o
);

  logic [W-1:0] shreg_q, shreg_d;
  logic         ser_q, ser_d;

  // Bit 0 goes straight to the output on load so it appears one cycle later.
  always_comb begin
    shreg_d = {1'b0, shreg_q[W-1:1]};
    ser_d   = shreg_q[0];
    if (load_i) begin
      shreg_d = {1'b0, sym_i[W-1:1]};
      ser_d   = sym_i[0];
    end else if (clr_i) begin
      shreg_d = '0;
      ser_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      ser_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      ser_q   <= ser_d;
    end
  end

  assign ser_o = ser_q;

endmodule
`default_nettype wire

// File: rtl/tmds_serial_sched.sv
`default_nettype none
// ============================================================================
// Module : tmds_serial_sched
// Brief  : Bit-rate TMDS scheduler: symbol fetch, 10:1 serialisation, underflow.
// Rev    : 1.0
// ============================================================================
module tmds_serial_sched
  import tmds_pkg::*;
#(
  parameter int UFL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  tmds_serial_sched_if.slave    bus,
  output logic                  pix_stb,
  output logic                  tmds_b,
  output logic                  tmds_g,
  output logic                  tmds_r,
  output logic                  tmds_clk,
  output logic                  running,
  output logic [UFL_W-1:0]      ufl_cnt,
  input  logic                  ufl_clr
);

  localparam int               CNT_W = $clog2(SYM_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SYM_W - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [UFL_W-1:0]   ufl_q, ufl_d;
  logic               pix_q;
  logic               tclk_q, tclk_d;
  logic               at_bound, load_slot, load, lane_clr;
  logic [SYM_W-1:0]   ld_b, ld_g, ld_r;

  assign at_bound  = (bit_cnt_q == LAST);
  assign load_slot = (state_q == IDLE) ? ena : at_bound;
  // A STOP boundary with ena re-asserted loads like RUN, so no gap symbol appears.
  assign load      = load_slot && ena && !rst;
  assign lane_clr  = (state_d == IDLE);

  assign ld_b = bus.sym_valid ? bus.sym_b : IDLE_SYM;
  assign ld_g = bus.sym_valid ? bus.sym_g : IDLE_SYM;
  assign ld_r = bus.sym_valid ? bus.sym_r : IDLE_SYM;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ena) state_d = RUN;
      RUN:     if (!ena) state_d = at_bound ? IDLE : STOP;
      STOP:    if (at_bound) state_d = ena ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE)
      bit_cnt_d = LAST;
    else
      bit_cnt_d = at_bound ? '0 : bit_cnt_q + CNT_W'(1);

    tclk_d = (state_d != IDLE) && CLK_PATTERN[bit_cnt_d];

    ufl_d = ufl_q;
    if (ufl_clr)
      ufl_d = '0;
    else if (load && !bus.sym_valid && !(&ufl_q))
      ufl_d = ufl_q + UFL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= LAST;
      ufl_q     <= '0;
      pix_q     <= 1'b0;
      tclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ufl_q     <= ufl_d;
      pix_q     <= load;
      tclk_q    <= tclk_d;
    end
  end

  tmds_lane_shift #(.W(SYM_W)) u_lane_b (
    .clk(clk), .rst(rst), .load_i(load), .clr_i(lane_clr), .sym_i(ld_b), .ser_o(tmds_b)
  );
  tmds_lane_shift #(.W(SYM_W)) u_lane_g (
    .clk(clk), .rst(rst), .load_i(load), .clr_i(lane_clr), .sym_i(ld_g), .ser_o(tmds_g)
  );
  tmds_lane_shift #(.W(SYM_W)) u_lane_r (
    .clk(clk), .rst(rst), .load_i(load), .clr_i(lane_clr), .sym_i(ld_r), .ser_o(tmds_r)
  );

  assign bus.sym_ready = load;
  assign pix_stb       = pix_q;
  assign tmds_clk      = tclk_q;
  assign running       = (state_q != IDLE);
  assign ufl_cnt       = ufl_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_serial_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_tmds_serial_sched
// Brief  : Scoreboard bench for tmds_serial_sched (driver pushes, monitor pops).
// Rev    : 1.0
// ============================================================================
module tb_tmds_serial_sched;

  typedef struct packed {
    logic [9:0] b;
    logic [9:0] g;
    logic [9:0] r;
  } trip_t;

  localparam logic [9:0] CTRL00 = 10'b1101010100;

  logic       clk = 1'b0;
  logic       rst, ena, ufl_clr;
  logic       pix_stb, tmds_b, tmds_g, tmds_r, tmds_clk, running;
  logic [7:0] ufl_cnt;

  tmds_serial_sched_if sif ();

  tmds_serial_sched #(.UFL_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bus(sif), .pix_stb(pix_stb),
    .tmds_b(tmds_b), .tmds_g(tmds_g), .tmds_r(tmds_r), .tmds_clk(tmds_clk),
    .running(running), .ufl_cnt(ufl_cnt), .ufl_clr(ufl_clr)
  );

  always #5 clk = ~clk;

  trip_t expq[$];
  trip_t mon_cur;
  int    mon_k   = 10;
  int    n_chk   = 0;
  int    n_err   = 0;
  int    exp_ufl = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit v, input logic [9:0] b, g, r);
    trip_t t;
    t.b = v ? b : CTRL00;
    t.g = v ? g : CTRL00;
    t.r = v ? r : CTRL00;
    expq.push_back(t);
  endtask

  // Called at the falling edge of a load-slot cycle; returns at the next one.
  task automatic slot(input bit v, input logic [9:0] b, g, r, input bit clr);
    ena = 1'b1; ufl_clr = clr;
    sif.sym_valid = v; sif.sym_b = b; sif.sym_g = g; sif.sym_r = r;
    #1;
    chk("sym_ready at slot", 32'(sif.sym_ready), 32'd1);
    push_exp(v, b, g, r);
    if (clr) exp_ufl = 0;
    else if (!v && exp_ufl != 255) exp_ufl++;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      ufl_clr = 1'b0;
      sif.sym_valid = 1'($urandom);
      sif.sym_b = 10'($urandom); sif.sym_g = 10'($urandom); sif.sym_r = 10'($urandom);
      #1;
      chk("sym_ready in gap", 32'(sif.sym_ready), 32'd0);
      if (j == 0) chk("ufl_cnt", 32'(ufl_cnt), 32'(exp_ufl));
    end
    @(negedge clk);
  endtask

  // Load one symbol, drop ena at bit drop_at, optionally re-raise at raise_at.
  task automatic stop_seq(input int drop_at, input int raise_at);
    logic [9:0] b, g, r;
    b = 10'($urandom); g = 10'($urandom); r = 10'($urandom);
    ena = 1'b1; sif.sym_valid = 1'b1; sif.sym_b = b; sif.sym_g = g; sif.sym_r = r;
    #1;
    chk("sym_ready stop-seq load", 32'(sif.sym_ready), 32'd1);
    push_exp(1'b1, b, g, r);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      sif.sym_valid = 1'($urandom);
      if (j == drop_at) ena = 1'b0;
      if (j == raise_at) ena = 1'b1;
      #1;
      chk("sym_ready while stopping", 32'(sif.sym_ready), 32'd0);
      if (j == 8) chk("running in STOP", 32'(running), 32'd1);
    end
    @(negedge clk);
    if (raise_at < 0) begin
      #1;
      chk("sym_ready at STOP boundary", 32'(sif.sym_ready), 32'd0);
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        #1;
        chk("running after stop", 32'(running), 32'd0);
        chk("sym_ready idle", 32'(sif.sym_ready), 32'd0);
      end
      @(negedge clk);
    end
  endtask

  // Monitor: each pix_stb starts one expected symbol; otherwise lanes must be quiet.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mon_k = 10;
      end else begin
        if (pix_stb) begin
          if (expq.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL pix_stb without accepted symbol at %0t", $time);
            mon_k = 10;
          end else begin
            mon_cur = expq.pop_front();
            mon_k   = 0;
          end
        end
        if (mon_k < 10) begin
          chk($sformatf("lanes bgr+clk bit %0d", mon_k),
              32'({tmds_b, tmds_g, tmds_r, tmds_clk}),
              32'({mon_cur.b[mon_k], mon_cur.g[mon_k], mon_cur.r[mon_k], 1'(mon_k < 5)}));
          mon_k++;
        end else begin
          chk("idle lanes", 32'({tmds_b, tmds_g, tmds_r, tmds_clk}), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    rst = 1'b1; ena = 1'b0; ufl_clr = 1'b0;
    sif.sym_valid = 1'b0; sif.sym_b = '0; sif.sym_g = '0; sif.sym_r = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset sym_ready", 32'(sif.sym_ready), 32'd0);
    chk("reset pix_stb", 32'(pix_stb), 32'd0);
    chk("reset running", 32'(running), 32'd0);
    chk("reset ufl_cnt", 32'(ufl_cnt), 32'd0);
    chk("reset lanes", 32'({tmds_b, tmds_g, tmds_r, tmds_clk}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      chk("idle sym_ready", 32'(sif.sym_ready), 32'd0);
      chk("idle running", 32'(running), 32'd0);
    end
    @(negedge clk);

    // Continuous stream, 0x2AB on blue
    repeat (3) slot(1'b1, 10'h2AB, 10'h155, 10'h3C7, 1'b0);
    slot(1'b0, 10'h111, 10'h222, 10'h333, 1'b0);
    slot(1'b1, 10'h0F0, 10'h30F, 10'h2AB, 1'b0);

    // Saturation and clear priority
    repeat (300) slot(1'b0, 10'($urandom), 10'($urandom), 10'($urandom), 1'b0);
    slot(1'b1, 10'h001, 10'h200, 10'h3FF, 1'b1);
    slot(1'b0, 10'h0, 10'h0, 10'h0, 1'b0);
    slot(1'b0, 10'h0, 10'h0, 10'h0, 1'b1);
    slot(1'b1, 10'h1A5, 10'h25A, 10'h0C3, 1'b0);

    // Graceful stop, restart from IDLE, then re-raise mid-STOP
    stop_seq(3, -1);
    slot(1'b1, 10'h2AB, 10'h155, 10'h3C7, 1'b0);
    stop_seq(3, 6);
    slot(1'b1, 10'h3E1, 10'h01E, 10'h2D2, 1'b0);

    // Asynchronous reset at bit 5, then immediate restart
    ena = 1'b1; sif.sym_valid = 1'b1;
    sif.sym_b = 10'h0F3; sif.sym_g = 10'h30C; sif.sym_r = 10'h2AA;
    #1;
    chk("sym_ready before reset", 32'(sif.sym_ready), 32'd1);
    push_exp(1'b1, 10'h0F3, 10'h30C, 10'h2AA);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      sif.sym_valid = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async rst lanes", 32'({tmds_b, tmds_g, tmds_r, tmds_clk}), 32'd0);
    chk("async rst pix_stb", 32'(pix_stb), 32'd0);
    chk("async rst running", 32'(running), 32'd0);
    chk("async rst ufl_cnt", 32'(ufl_cnt), 32'd0);
    chk("async rst sym_ready", 32'(sif.sym_ready), 32'd0);
    exp_ufl = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    slot(1'b1, 10'h2AB, 10'h155, 10'h3C7, 1'b0);

    // Random valid/stall stream
    for (int i = 0; i < 1000; i++)
      slot($urandom_range(0, 3) != 0, 10'($urandom), 10'($urandom), 10'($urandom), 1'b0);

    ena = 1'b0; sif.sym_valid = 1'b0;
    #1;
    chk("sym_ready final", 32'(sif.sym_ready), 32'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("final running", 32'(running), 32'd0);
    chk("scoreboard drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
